// File: rtl/cond_logic.sv
// cond_logic: condition evaluation and flag holding for the multicycle core.
// Holds the architectural N/Z/C/V flags, evaluates the instruction condition
// field against them, and gates the controller's PC / register / memory
// write requests with the latched condition result.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   cond[3:0]            instruction condition field
//   alu_n/z/c/v          ALU flag outputs for this cycle
//   flag_w[1:0]          [1] updates N,Z; [0] updates C,V
//   cond_latch           decode strobe capturing the condition result
//   pcs, reg_w, mem_w    controller write requests
//   no_write             compare-type instruction, blocks register write
//   pc_write, reg_write, mem_write  gated write enables (combinational)
//   cond_ex              latched condition-passed bit
//   flags[3:0]           held flags {N,Z,C,V}
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [1:0] flag_w,
  input  logic       cond_latch,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags
);

  localparam int unsigned FLAG_W = 4;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  logic [FLAG_W-1:0] nzcv;
  logic              cond_ex_q;
  logic              cond_pass;
  logic              f_n;
  logic              f_z;
  logic              f_c;
  logic              f_v;
  logic              ge;

  assign f_n = nzcv[3];
  assign f_z = nzcv[2];
  assign f_c = nzcv[1];
  assign f_v = nzcv[0];
  assign ge  = (f_n == f_v);

  // Condition evaluation against held flags only; incoming ALU flags are
  // never forwarded. The reserved encoding 1111 falls to the default (fail).
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = f_z;
      COND_NE: cond_pass = ~f_z;
      COND_CS: cond_pass = f_c;
      COND_CC: cond_pass = ~f_c;
      COND_MI: cond_pass = f_n;
      COND_PL: cond_pass = ~f_n;
      COND_VS: cond_pass = f_v;
      COND_VC: cond_pass = ~f_v;
      COND_HI: cond_pass = f_c & ~f_z;
      COND_LS: cond_pass = ~f_c | f_z;
      COND_GE: cond_pass = ge;
      COND_LT: cond_pass = ~ge;
      COND_GT: cond_pass = ~f_z & ge;
      COND_LE: cond_pass = f_z | ~ge;
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Condition result register, captured on the decode strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_ex_q <= 1'b0;
    end else if (cond_latch) begin
      cond_ex_q <= cond_pass;
    end
  end

  // Flag register; writes are qualified by the pre-edge condition result,
  // i.e. the instruction currently executing, not one being latched now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv <= '0;
    end else if (cond_ex_q) begin
      if (flag_w[1]) begin
        nzcv[3] <= alu_n;
        nzcv[2] <= alu_z;
      end
      if (flag_w[0]) begin
        nzcv[1] <= alu_c;
        nzcv[0] <= alu_v;
      end
    end
  end

  // Write gating straight from registered state, no extra stage.
  assign pc_write  = pcs & cond_ex_q;
  assign reg_write = reg_w & cond_ex_q & ~no_write;
  assign mem_write = mem_w & cond_ex_q;
  assign cond_ex   = cond_ex_q;
  assign flags     = nzcv;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic.
module tb_cond_logic;

  logic       clk;
  logic       reset;
  logic [3:0] cond;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic [1:0] flag_w;
  logic       cond_latch;
  logic       pcs, reg_w, mem_w, no_write;
  logic       pc_write, reg_write, mem_write, cond_ex;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  cond_logic dut (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .flag_w     (flag_w),
    .cond_latch (cond_latch),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .no_write   (no_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .cond_ex    (cond_ex),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] v);
    {alu_n, alu_z, alu_c, alu_v} = v;
  endtask

  // Latch condition c at the next edge.
  task automatic latch(input logic [3:0] c);
    cond = c;
    cond_latch = 1'b1;
    tick();
    cond_latch = 1'b0;
  endtask

  // Load nzcv = v via an AL instruction writing all flags; leaves cond_ex=1.
  task automatic set_flags(input logic [3:0] v);
    flag_w = 2'b00;
    latch(4'b1110);
    set_alu(v);
    flag_w = 2'b11;
    tick();
    flag_w = 2'b00;
    set_alu(4'b0000);
  endtask

  // Independent reference for the condition table.
  function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    cond = 4'b0000; cond_latch = 1'b0; flag_w = 2'b00;
    set_alu(4'b0000);
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;

    // Reset state before any clock edge.
    #2;
    check4("rst_flags", flags, 4'b0000);
    check1("rst_cond_ex", cond_ex, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-cycle with flags=1111, cond_ex=1.
    set_flags(4'b1111);
    check4("pre_rst_flags", flags, 4'b1111);
    check1("pre_rst_cond_ex", cond_ex, 1'b1);
    pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    #1;
    check1("pre_rst_pc_write", pc_write, 1'b1);
    check1("pre_rst_reg_write", reg_write, 1'b1);
    check1("pre_rst_mem_write", mem_write, 1'b1);
    #1 reset = 1'b1;
    #1;
    check4("arst_flags", flags, 4'b0000);
    check1("arst_cond_ex", cond_ex, 1'b0);
    check1("arst_pc_write", pc_write, 1'b0);
    check1("arst_reg_write", reg_write, 1'b0);
    check1("arst_mem_write", mem_write, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check1("post_rst_no_latch_pc_write", pc_write, 1'b0);
    check1("post_rst_no_latch_mem_write", mem_write, 1'b0);
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;

    // Hand-picked points: nzcv=1001 -> GE pass, LT fail.
    set_flags(4'b1001);
    latch(4'b1010);
    check1("nzcv1001_GE", cond_ex, 1'b1);
    latch(4'b1011);
    check1("nzcv1001_LT", cond_ex, 1'b0);
    latch(4'b1111);
    check1("nzcv1001_NV", cond_ex, 1'b0);

    // Full condition sweep.
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      check4($sformatf("sweep_flags_%0d", f), flags, 4'(f));
      for (int c = 0; c < 16; c++) begin
        latch(4'(c));
        check1($sformatf("sweep_f%0d_c%0d", f, c), cond_ex, exp_pass(4'(c), 4'(f)));
      end
    end

    // Partial flag writes.
    set_flags(4'b0000);
    set_alu(4'b1111);
    flag_w = 2'b10;
    tick();
    check4("partial_nz", flags, 4'b1100);
    flag_w = 2'b01;
    tick();
    check4("partial_cv", flags, 4'b1111);
    set_alu(4'b0000);
    flag_w = 2'b00;
    tick();
    check4("partial_none", flags, 4'b1111);

    // Suppressed instruction: EQ fails with Z=0.
    set_flags(4'b0000);
    latch(4'b0000);
    check1("supp_cond_ex", cond_ex, 1'b0);
    pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    flag_w = 2'b11; set_alu(4'b1111);
    #1;
    check1("supp_pc_write", pc_write, 1'b0);
    check1("supp_reg_write", reg_write, 1'b0);
    check1("supp_mem_write", mem_write, 1'b0);
    tick();
    check4("supp_flags", flags, 4'b0000);
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    flag_w = 2'b00; set_alu(4'b0000);

    // CMP (AL, no_write) setting Z, then conditional branch on EQ.
    set_flags(4'b0000);
    no_write = 1'b1; reg_w = 1'b1; flag_w = 2'b11;
    set_alu(4'b0100);
    #1;
    check1("cmp_reg_write", reg_write, 1'b0);
    tick();
    check4("cmp_flags", flags, 4'b0100);
    no_write = 1'b0; reg_w = 1'b0; flag_w = 2'b00; set_alu(4'b0000);
    latch(4'b0000);
    check1("beq_cond_ex", cond_ex, 1'b1);
    pcs = 1'b1;
    #1;
    check1("beq_pc_write", pc_write, 1'b1);
    pcs = 1'b0; reg_w = 1'b1;
    #1;
    check1("beq_reg_write_ok", reg_write, 1'b1);
    reg_w = 1'b0;

    // Simultaneous latch and flag write: latch sees old Z.
    set_flags(4'b0000);
    cond = 4'b0000; cond_latch = 1'b1;
    flag_w = 2'b10; set_alu(4'b0100);
    tick();
    cond_latch = 1'b0; flag_w = 2'b00; set_alu(4'b0000);
    check1("simul_cond_ex", cond_ex, 1'b0);
    check4("simul_flags", flags, 4'b0100);
    latch(4'b0000);
    check1("simul_relatch_cond_ex", cond_ex, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
# cond_logic

Condition-evaluation and flag-holding block for the 8-bit multicycle ARM-style processor. It latches the N/Z/C/V flags produced by the ALU, evaluates the 4-bit ARM condition field of the current instruction against the held flags, and gates the architectural write enables (PC, register file, memory) that the multicycle controller requests. It sits between the controller/decoder and the datapath, on the consuming side of the ALU flag outputs.

## Interface
- No parameters (flag width 4, condition field width 4, both fixed).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cond  in  4  instruction condition field, bits [31:28] equivalent
- alu_n, alu_z, alu_c, alu_v  in  1 each  negative/zero/carry/overflow flags from the ALU, this cycle
- flag_w  in  2  flag write request; [1] = update N,Z; [0] = update C,V
- cond_latch  in  1  controller strobe in the decode state; captures the condition result
- pcs  in  1  controller request to write PC (branch/PC-destination)
- reg_w  in  1  controller request to write register file
- mem_w  in  1  controller request to write memory
- no_write  in  1  instruction is compare-type (CMP/TST); suppresses register write
- pc_write  out  1  gated PC write enable
- reg_write  out  1  gated register-file write enable
- mem_write  out  1  gated memory write enable
- cond_ex  out  1  registered condition-passed bit for the current instruction
- flags  out  4  held flags {N,Z,C,V}

## Operation
- State: flags register nzcv[3:0], condition register cond_ex_q.
- Combinational evaluation cond_pass = f(cond, nzcv), ARM encoding:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 reserved, evaluates 0 (instruction never executes)
- cond_latch=1 at a rising edge: cond_ex_q <= cond_pass; otherwise cond_ex_q holds.
- Flag update at a rising edge, only if cond_ex_q=1:
  - flag_w[1]: N <= alu_n, Z <= alu_z
  - flag_w[0]: C <= alu_c, V <= alu_v
  - cond_ex_q=0: flags hold regardless of flag_w.
- Write gating, combinational from registered state:
  - pc_write = pcs & cond_ex_q
  - reg_write = reg_w & cond_ex_q & !no_write
  - mem_write = mem_w & cond_ex_q
- cond_ex = cond_ex_q; flags = nzcv.

## Timing
- Reset (asynchronous assert, any time): nzcv=0000, cond_ex_q=0; hence pc_write=reg_write=mem_write=0, cond_ex=0, flags=0000 immediately, without a clock edge.
- Reset deassertion: first active edge is the first clk rising edge with reset low.
- Reset mid-instruction: pending condition result and flags discarded; no write enable may assert until a new cond_latch.
- cond_latch latency: cond_ex valid one cycle after the strobe edge; write enables in the same cycle follow within combinational delay.
- Flag latency: ALU flags sampled at the edge; new flags visible on flags and used by cond_pass the following cycle.
- Simultaneous cond_latch and flag write in one cycle: cond_latch evaluates against the pre-edge flags; the flag write is qualified by the pre-edge cond_ex_q (previous instruction). No forwarding of incoming ALU flags into cond_pass.
- flag_w=11 writes all four flags in one edge; flag_w=00 writes none.
- Outputs are glitch-tolerant combinational ANDs; no extra register stage.

## Test plan
- Reset: assert reset asynchronously mid-cycle with flags=1111, cond_ex=1 -> flags=0000, cond_ex=0, all write enables 0 before the next edge.
- Condition sweep: for each of the 16 nzcv values, drive all 16 cond values with cond_latch pulse -> cond_ex matches the table (e.g. nzcv=1001, GE -> 1, LT -> 0; cond=1111 -> 0 always).
- Partial flag write: nzcv=0000, cond_ex=1, alu n,z,c,v=1,1,1,1, flag_w=10 -> flags=1100; then flag_w=01 -> 1111.
- Suppressed instruction: nzcv=0000, cond=0000 (EQ) latched -> cond_ex=0; pcs=reg_w=mem_w=1, flag_w=11 with alu flags 1111 -> all enables 0, flags stay 0000.
- CMP then conditional branch: cond=AL, flag_w=11, no_write=1, reg_w=1, alu_z=1 -> reg_write=0, flags=0100 next cycle; then cond=EQ latched, pcs=1 -> pc_write=1.
- Simultaneous latch/write: cond_ex_q=1, flag_w=10, alu_z=1 with nzcv=0000 and cond=EQ latched same edge -> cond_ex=0 (old Z), flags=0100.
